dictionary_decoder: RTL and testbench

Decompression side of the team's dictionary-based compression datapath. The block consumes a stream of 9-bit tokens, each either a literal byte or a reference into a 16-bucket × 4-way dictionary. It rebuilds that dictionary in lock-step with the compressor's hash table and emits the reconstructed byte stream. Input and output are both valid/ready streams, and a reference token may expand into up to four repeated output bytes.

---
 rtl/dict_pkg.sv | 27 ++
 rtl/dict_store.sv | 51 +++++
 rtl/dictionary_decoder.sv | 93 +++++++++
 tb/tb_dictionary_decoder.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/dict_pkg.sv
// Shared definitions for the dictionary compressor/decompressor pair:
// table geometry, token field positions, bucket hash and decoder FSM states.
package dict_pkg;

  localparam int HASH_TABLE_SIZE = 16;
  localparam int CHAIN_LENGTH    = 4;

  localparam int TOK_W       = 9;
  localparam int TOK_LIT_BIT = 8;
  localparam int TOK_BKT_HI  = 7;
  localparam int TOK_BKT_LO  = 4;
  localparam int TOK_WAY_HI  = 3;
  localparam int TOK_WAY_LO  = 2;
  localparam int TOK_REP_HI  = 1;
  localparam int TOK_REP_LO  = 0;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  // Must stay bit-identical to the compressor's bucket selection.
  function automatic logic [3:0] dict_hash(input logic [7:0] b);
    return b[3:0] ^ b[7:4];
  endfunction

endpackage

// File: rtl/dict_store.sv
// Dictionary storage: 16 buckets x 4 ways of bytes with valid bits and
// per-bucket fill pointers, duplicate-suppressing insert and a combinational read port.
module dict_store
  import dict_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_byte,
  input  logic [3:0]        rd_bucket,
  input  logic [1:0]        rd_way,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid
);

  logic [DATA_W-1:0]       mem [HASH_TABLE_SIZE][CHAIN_LENGTH];
  logic [CHAIN_LENGTH-1:0] vld [HASH_TABLE_SIZE];
  logic [1:0]              fp  [HASH_TABLE_SIZE];

  logic [3:0] wr_bkt;
  logic       hit;

  always_comb begin
    wr_bkt = dict_hash(wr_byte);
    hit    = 1'b0;
    for (int i = 0; i < CHAIN_LENGTH; i++) begin
      if (vld[wr_bkt][i] && (mem[wr_bkt][i] == wr_byte)) hit = 1'b1;
    end
  end

  // Contents are cleared too, so an empty entry reads back as 0x00.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int b = 0; b < HASH_TABLE_SIZE; b++) begin
        vld[b] <= '0;
        fp[b]  <= 2'd0;
        for (int w = 0; w < CHAIN_LENGTH; w++) mem[b][w] <= '0;
      end
    end else if (wr_en && !hit) begin
      mem[wr_bkt][fp[wr_bkt]] <= wr_byte;
      vld[wr_bkt][fp[wr_bkt]] <= 1'b1;
      fp[wr_bkt]              <= fp[wr_bkt] + 2'd1;
    end
  end

  assign rd_data  = mem[rd_bucket][rd_way];
  assign rd_valid = vld[rd_bucket][rd_way];

endmodule

// File: rtl/dictionary_decoder.sv
// Token-stream dictionary decoder: literals pass through and train the dictionary,
// references replay a stored byte 1-4 times. Build option: DICT_DEC_ERR_EN.
module dictionary_decoder
  import dict_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [TOK_W-1:0] tok_in,
  input  logic             tok_valid,
  output logic             tok_ready,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             err
);

  state_e     state;
  logic [1:0] rem;
  logic       accept;
  logic       out_fire;
  logic       is_lit;
  logic       ref_ok;
  logic [1:0] rep_n;
  logic [7:0] rd_data;
  logic       rd_valid;

  assign tok_ready = reset && (state == IDLE) && (!out_valid || out_ready);
  assign accept    = tok_valid && tok_ready;
  assign out_fire  = out_valid && out_ready;
  assign is_lit    = tok_in[TOK_LIT_BIT];
  assign rep_n     = tok_in[TOK_REP_HI:TOK_REP_LO];

  dict_store #(
    .DATA_W(8)
  ) u_store (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (accept && is_lit),
    .wr_byte  (tok_in[7:0]),
    .rd_bucket(tok_in[TOK_BKT_HI:TOK_BKT_LO]),
    .rd_way   (tok_in[TOK_WAY_HI:TOK_WAY_LO]),
    .rd_data  (rd_data),
    .rd_valid (rd_valid)
  );

`ifdef DICT_DEC_ERR_EN
  assign ref_ok = rd_valid;
`else
  logic unused_rd_valid;
  assign unused_rd_valid = rd_valid;
  assign ref_ok          = 1'b1;
`endif

  // Output register: repeats re-present the held byte, so only rem changes in EMIT.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      rem       <= 2'd0;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (out_fire) out_valid <= 1'b0;
          if (accept) begin
            if (is_lit) begin
              out_data  <= tok_in[7:0];
              out_valid <= 1'b1;
            end else if (ref_ok) begin
              out_data  <= rd_data;
              out_valid <= 1'b1;
              if (rep_n != 2'd0) begin
                state <= EMIT;
                rem   <= rep_n;
              end
            end else begin
              err <= 1'b1;
            end
          end
        end
        EMIT: begin
          if (out_fire) begin
            rem <= rem - 2'd1;
            if (rem == 2'd1) state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dictionary_decoder.sv
// Directed self-checking bench for dictionary_decoder; error-path expectations
// follow whether DICT_DEC_ERR_EN is defined for the build.
module tb_dictionary_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic [8:0] tok_in;
  logic       tok_valid;
  logic       tok_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dictionary_decoder dut (
    .clk      (clk),
    .reset    (reset),
    .tok_in   (tok_in),
    .tok_valid(tok_valid),
    .tok_ready(tok_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .err      (err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present a token and hold it until accepted; returns #1 after the accepting edge.
  task automatic send(input logic [8:0] tok);
    bit done;
    done      = 1'b0;
    tok_in    = tok;
    tok_valid = 1'b1;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (tok_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    tok_valid = 1'b0;
    if (!done) chk($sformatf("accept_timeout_%03h", tok), 32'd0, 32'd1);
  endtask

  // Check the presented byte, then let it be consumed at the next edge.
  task automatic get(input string tag, input logic [7:0] exp);
    chk({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_dat"}, {24'd0, out_data}, {24'd0, exp});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
  endtask

  initial begin
    reset     = 1'b0;
    tok_in    = 9'h000;
    tok_valid = 1'b0;
    out_ready = 1'b1;

    // Reset state
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'h00);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_tok_ready", {31'd0, tok_ready}, 32'd0);
    reset = 1'b1;
    #1;
    chk("post_rst_tok_ready", {31'd0, tok_ready}, 32'd1);

    // Literal 0x5A -> bucket F way 0, then reference F/0 x3
    send(9'h15A);
    get("lit5a", 8'h5A);
    send(9'h0F2);
    chk("emit_tok_ready", {31'd0, tok_ready}, 32'd0);
    get("ref_f0_r0", 8'h5A);
    get("ref_f0_r1", 8'h5A);
    get("ref_f0_r2", 8'h5A);
    chk("after_ref_idle", {31'd0, out_valid}, 32'd0);

    // Duplicate literal is not re-inserted; 0xA5 lands in way 1
    send(9'h15A);
    get("dup5a", 8'h5A);
    send(9'h1A5);
    get("lita5", 8'hA5);
    send(9'h0F4);
    get("ref_f1", 8'hA5);
    chk("ref_f1_single", {31'd0, out_valid}, 32'd0);

    // Bucket 0 overflow: fifth literal overwrites way 0
    send(9'h100); get("lit00", 8'h00);
    send(9'h111); get("lit11", 8'h11);
    send(9'h122); get("lit22", 8'h22);
    send(9'h133); get("lit33", 8'h33);
    send(9'h144); get("lit44", 8'h44);
    send(9'h000); get("ref_00", 8'h44);
    send(9'h00C); get("ref_03", 8'h33);
    send(9'h004); get("ref_01", 8'h11);

    // Backpressure during a 4-repeat reference
    send(9'h0F3);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("bp_vld_%0d", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("bp_dat_%0d", i), {24'd0, out_data}, 32'h5A);
      chk($sformatf("bp_rdy_%0d", i), {31'd0, tok_ready}, 32'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) get($sformatf("bp_rep_%0d", i), 8'h5A);
    chk("bp_exactly4", {31'd0, out_valid}, 32'd0);

    // Reference to an empty entry after reset
    do_reset();
    send(9'h004);
`ifdef DICT_DEC_ERR_EN
    chk("empty_err_pulse", {31'd0, err}, 32'd1);
    chk("empty_no_out", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    chk("empty_err_clear", {31'd0, err}, 32'd0);
`else
    chk("empty_err_low", {31'd0, err}, 32'd0);
    get("empty_zero", 8'h00);
    chk("empty_once", {31'd0, out_valid}, 32'd0);
`endif
    send(9'h1C3);
    get("lit_c3", 8'hC3);

    // Reset in the second cycle of a 4-repeat emit (0xC3 is in bucket F way 0)
    send(9'h0F3);
    get("mid_first", 8'hC3);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_vld", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_rdy", {31'd0, tok_ready}, 32'd0);
    reset = 1'b1;
    #1;
    chk("mid_rst_rdy_back", {31'd0, tok_ready}, 32'd1);
    send(9'h0F0);
`ifdef DICT_DEC_ERR_EN
    chk("mid_dict_empty_err", {31'd0, err}, 32'd1);
    chk("mid_dict_empty_vld", {31'd0, out_valid}, 32'd0);
`else
    get("mid_dict_empty", 8'h00);
`endif

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
